probe_conditioner: RTL and testbench

- Front-end stage that produces the x/y sample bits fed into the correlator's `i_x`/`i_y`.
- Synchronises two asynchronous probe pins and glitch-filters them.
- Converts each to a level or edge event per a mode select.
- Sticky-captures events between sample strobes, so activity shorter than a sample period is never lost.

---
 rtl/probe_conditioner_pkg.sv | 24 ++
 rtl/probe_channel.sv | 106 ++++++++++
 rtl/probe_conditioner.sv | 65 ++++++
 tb/tb_probe_conditioner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_conditioner_pkg.sv
// Shared definitions for the probe conditioner: event-mode encodings (matching the register map)
// and the per-mode event decode.
package probe_conditioner_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'd0,
        MODE_RISE  = 2'd1,
        MODE_FALL  = 2'd2,
        MODE_ANY   = 2'd3
    } mode_e;

    function automatic logic event_of(input mode_e mode, input logic cur, input logic prev);
        logic ev;
        unique case (mode)
            MODE_LEVEL: ev = cur;
            MODE_RISE:  ev = cur & ~prev;
            MODE_FALL:  ev = ~cur & prev;
            MODE_ANY:   ev = cur ^ prev;
            default:    ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/probe_channel.sv
// One probe pin: synchroniser, glitch filter, event decode and sticky capture.
// Optional saturating event counter under PROBE_CONDITIONER_EVENT_COUNT_EN.
module probe_channel
    import probe_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_W    = 4,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cg,
    input  logic                i_pin,
    input  logic [1:0]          i_mode,
    input  logic [FILTER_W-1:0] i_filterLen,
    input  logic                i_sampleStrobe,
`ifdef PROBE_CONDITIONER_EVENT_COUNT_EN
    input  logic                i_clearCounts,
    output logic [COUNT_W-1:0]  o_eventCount,
`endif
    output logic                o_out
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d;
    logic [FILTER_W-1:0]    cnt_q, cnt_d;
    logic                   prev_q, prev_d;
    logic                   sticky_q, sticky_d;
    logic                   out_q, out_d;
    logic                   sync;
    logic                   ev;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_pin};
        sync   = sync_q[SYNC_STAGES-1];

        filt_d = filt_q;
        cnt_d  = cnt_q;
        // A change is accepted only after i_filterLen+1 consecutive differing cycles
        if (sync == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == i_filterLen) begin
            filt_d = sync;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        prev_d = filt_q;
        ev     = event_of(mode_e'(i_mode), filt_q, prev_q);

        if (i_sampleStrobe) begin
            out_d    = sticky_q | ev;
            sticky_d = 1'b0;
        end else begin
            out_d    = out_q;
            sticky_d = sticky_q | ev;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q   <= '0;
            filt_q   <= 1'b0;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            sticky_q <= 1'b0;
            out_q    <= 1'b0;
        end else if (i_cg) begin
            sync_q   <= sync_d;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            sticky_q <= sticky_d;
            out_q    <= out_d;
        end
    end

    assign o_out = out_q;

`ifdef PROBE_CONDITIONER_EVENT_COUNT_EN
    logic [COUNT_W-1:0] ecnt_q, ecnt_d;

    always_comb begin
        ecnt_d = ecnt_q;
        if (i_clearCounts) begin
            ecnt_d = '0;
        end else if (ev && (ecnt_q != {COUNT_W{1'b1}})) begin
            ecnt_d = ecnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ecnt_q <= '0;
        end else if (i_cg) begin
            ecnt_q <= ecnt_d;
        end
    end

    assign o_eventCount = ecnt_q;
`else
    // Event counters compiled out.
`endif

endmodule

// File: rtl/probe_conditioner.sv
// Conditions the X/Y probe pins into strobe-aligned sample bits for the correlator.
// Macro PROBE_CONDITIONER_EVENT_COUNT_EN adds per-channel saturating event counters.
module probe_conditioner
    import probe_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_W    = 4,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cg,
    input  logic                i_probeX,
    input  logic                i_probeY,
    input  logic [1:0]          i_mode,
    input  logic [FILTER_W-1:0] i_filterLen,
    input  logic                i_sampleStrobe,
`ifdef PROBE_CONDITIONER_EVENT_COUNT_EN
    input  logic                i_clearCounts,
    output logic [COUNT_W-1:0]  o_eventCountX,
    output logic [COUNT_W-1:0]  o_eventCountY,
`endif
    output logic                o_x,
    output logic                o_y
);

    probe_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_W    (FILTER_W),
        .COUNT_W     (COUNT_W)
    ) u_chan_x (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_cg           (i_cg),
        .i_pin          (i_probeX),
        .i_mode         (i_mode),
        .i_filterLen    (i_filterLen),
        .i_sampleStrobe (i_sampleStrobe),
`ifdef PROBE_CONDITIONER_EVENT_COUNT_EN
        .i_clearCounts  (i_clearCounts),
        .o_eventCount   (o_eventCountX),
`endif
        .o_out          (o_x)
    );

    probe_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_W    (FILTER_W),
        .COUNT_W     (COUNT_W)
    ) u_chan_y (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_cg           (i_cg),
        .i_pin          (i_probeY),
        .i_mode         (i_mode),
        .i_filterLen    (i_filterLen),
        .i_sampleStrobe (i_sampleStrobe),
`ifdef PROBE_CONDITIONER_EVENT_COUNT_EN
        .i_clearCounts  (i_clearCounts),
        .o_eventCount   (o_eventCountY),
`endif
        .o_out          (o_y)
    );

endmodule

// File: tb/tb_probe_conditioner.sv
// Scoreboard bench for probe_conditioner: each strobe pushes the expected {o_x,o_y};
// a monitor pops on the cycle after every strobe and checks that outputs hold otherwise.
module tb_probe_conditioner;

    localparam int unsigned FILTER_W = 4;
    localparam int unsigned COUNT_W  = 8;

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b1;
    logic                i_cg = 1'b1;
    logic                i_probeX = 1'b0;
    logic                i_probeY = 1'b0;
    logic [1:0]          i_mode = 2'd0;
    logic [FILTER_W-1:0] i_filterLen = '0;
    logic                i_sampleStrobe = 1'b0;
    logic                o_x;
    logic                o_y;
`ifdef PROBE_CONDITIONER_EVENT_COUNT_EN
    logic                i_clearCounts = 1'b0;
    logic [COUNT_W-1:0]  o_eventCountX;
    logic [COUNT_W-1:0]  o_eventCountY;
`endif

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q[$];
    logic       pres;
    logic       last_x = 1'b0;
    logic       last_y = 1'b0;

    probe_conditioner #(
        .SYNC_STAGES (2),
        .FILTER_W    (FILTER_W),
        .COUNT_W     (COUNT_W)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_cg           (i_cg),
        .i_probeX       (i_probeX),
        .i_probeY       (i_probeY),
        .i_mode         (i_mode),
        .i_filterLen    (i_filterLen),
        .i_sampleStrobe (i_sampleStrobe),
`ifdef PROBE_CONDITIONER_EVENT_COUNT_EN
        .i_clearCounts  (i_clearCounts),
        .o_eventCountX  (o_eventCountX),
        .o_eventCountY  (o_eventCountY),
`endif
        .o_x            (o_x),
        .o_y            (o_y)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Marks the cycle in which the DUT presents a freshly strobed sample.
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) pres <= 1'b0;
        else       pres <= i_sampleStrobe & i_cg;
    end

    always @(negedge i_clk) begin
        logic [1:0] e;
        if (i_rst) begin
            last_x = 1'b0;
            last_y = 1'b0;
        end else if (pres) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample at %0t: got x=%0b y=%0b expected none",
                         $time, o_x, o_y);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_x", {31'd0, o_x}, {31'd0, e[1]});
                chk("strobe_y", {31'd0, o_y}, {31'd0, e[0]});
                last_x = e[1];
                last_y = e[0];
            end
        end else begin
            chk("hold_x", {31'd0, o_x}, {31'd0, last_x});
            chk("hold_y", {31'd0, o_y}, {31'd0, last_y});
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic strobe(input logic ex, input logic ey);
        i_sampleStrobe = 1'b1;
        exp_q.push_back({ex, ey});
        @(posedge i_clk);
        #1;
        i_sampleStrobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got timeout expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Reset: outputs clear immediately on a mid-cycle async reset
        i_probeX = 1'b1;
        i_probeY = 1'b1;
        run(6);
        strobe(1'b1, 1'b1);
        #6;
        i_rst = 1'b1;
        i_probeX = 1'b0;
        #1;
        chk("async_reset_x", {31'd0, o_x}, 32'd0);
        chk("async_reset_y", {31'd0, o_y}, 32'd0);
        i_probeY = 1'b0;
        @(posedge i_clk);
        #1;
        chk("reset_held_x", {31'd0, o_x}, 32'd0);
        run(1);
        i_rst = 1'b0;
        run(7);
        strobe(1'b0, 1'b0);

        // Level mode, no filtering: a 1-cycle pulse lasts one period
        run(2);
        i_probeX = 1'b1;
        run(1);
        i_probeX = 1'b0;
        run(4);
        strobe(1'b1, 1'b0);
        run(7);
        strobe(1'b0, 1'b0);

        // Filter length 3: a 3-cycle pulse is rejected, a 4-cycle pulse passes
        i_filterLen = 4'd3;
        run(1);
        i_probeX = 1'b1;
        run(3);
        i_probeX = 1'b0;
        run(9);
        strobe(1'b0, 1'b0);
        run(1);
        i_probeX = 1'b1;
        run(4);
        i_probeX = 1'b0;
        run(9);
        strobe(1'b1, 1'b0);
        run(7);
        strobe(1'b0, 1'b0);
        i_filterLen = 4'd0;

        // Rise mode with a long high, then fall mode on release
        i_mode = 2'd1;
        i_probeX = 1'b1;
        run(7);
        strobe(1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            run(7);
            strobe(1'b0, 1'b0);
        end
        i_mode = 2'd2;
        i_probeX = 1'b0;
        run(7);
        strobe(1'b1, 1'b0);
        run(7);
        strobe(1'b0, 1'b0);

        // Any-edge mode: Y edge coincides with the strobe and is not carried over
        i_mode = 2'd3;
        i_probeY = 1'b1;
        run(3);
        strobe(1'b0, 1'b1);
        run(7);
        strobe(1'b0, 1'b0);

        // Strobe held high: o_x is ev delayed by one cycle
        i_probeX = 1'b1;
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);

`ifdef PROBE_CONDITIONER_EVENT_COUNT_EN
        // Counters: clear, saturate, clear wins over a coincident event
        i_mode = 2'd1;
        i_probeX = 1'b0;
        run(4);
        i_clearCounts = 1'b1;
        run(1);
        i_clearCounts = 1'b0;
        run(1);
        chk("count_cleared_x", {24'd0, o_eventCountX}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            i_probeX = 1'b1;
            run(2);
            i_probeX = 1'b0;
            run(2);
        end
        run(4);
        chk("count_sat_x", {24'd0, o_eventCountX}, 32'd255);
        chk("count_idle_y", {24'd0, o_eventCountY}, 32'd0);
        i_clearCounts = 1'b1;
        run(1);
        i_clearCounts = 1'b0;
        chk("count_clear_pulse_x", {24'd0, o_eventCountX}, 32'd0);
        i_probeX = 1'b1;
        run(3);
        i_clearCounts = 1'b1;
        run(1);
        i_clearCounts = 1'b0;
        run(1);
        chk("count_clear_vs_event_x", {24'd0, o_eventCountX}, 32'd0);
        i_probeX = 1'b0;
        run(7);
        strobe(1'b1, 1'b0);
        run(7);
        strobe(1'b0, 1'b0);
`endif

        run(3);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
